// File: rtl/ram_dp_sr_sw_clr_if.sv
// rtl/ram_dp_sr_sw_clr_if.sv - write/read/clear bus bundle for ram_dp_sr_sw_clr
//
// Groups every non-clock, non-reset signal of the RAM.
//   clr      : one-cycle zero-fill request
//   busy     : clear sweep in progress
//   wr_*     : write strobe, address, data, lane enables
//   rd_*     : read strobe, address, returned data, returned-data valid
// master drives requests; slave (the RAM) drives busy/rd_data/rd_valid.

interface ram_dp_sr_sw_clr_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int LANE_WIDTH = 8
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  clr;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_LANES-1:0]  wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output clr, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/ram_dp_sr_sw_clr.sv
// rtl/ram_dp_sr_sw_clr.sv - simple dual-port RAM with byte enables and clear sweep
//
// One write port, one read port, per-lane write enables, selectable
// read-during-write behaviour, optional read output register and a clear
// sequencer that zero-fills the array after reset or on clr.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ram_dp_sr_sw_clr_if.slave (clr, busy, wr_*, rd_*)

module ram_dp_sr_sw_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int LANE_WIDTH = 8,
    parameter int RD_MODE    = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_dp_sr_sw_clr_if.slave     bus
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic                  w_busy;
    logic                  w_block;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_fwd;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                // clr is ignored here: an active sweep never restarts
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == C_LAST_ADDR) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                if (bus.clr) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
        endcase
    end

    assign w_busy   = (r_state == ST_CLEAR);
    // the cycle that samples clr in IDLE already belongs to the clear
    assign w_block  = w_busy | bus.clr;
    assign w_wr_acc = bus.wr_en & ~w_block;
    assign w_rd_acc = bus.rd_en & ~w_block;
    assign bus.busy = w_busy;

    // ---------------- storage ----------------
    // No reset on the array: the sweep is the only way contents get zeroed.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (bus.wr_be[i]) begin
                    r_mem[bus.wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // ---------------- read path ----------------
    assign w_rd_old = r_mem[bus.rd_addr];

    // Post-write view of the read word: enabled lanes from wr_data.
    always_comb begin
        w_rd_fwd = w_rd_old;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.wr_be[i]) begin
                w_rd_fwd[i*LANE_WIDTH +: LANE_WIDTH] = bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign w_rd_word = ((RD_MODE != 0) && w_wr_acc && (bus.wr_addr == bus.rd_addr)) ? w_rd_fwd : w_rd_old;

    // Data registers only load on an accepted read so rd_data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            // Not gated by busy: reads already in flight when clr arrives complete.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bus.rd_valid = r_s2_valid;
            assign bus.rd_data  = r_s2_data;
        end else begin : g_no_out_reg
            assign bus.rd_valid = r_s1_valid;
            assign bus.rd_data  = r_s1_data;
        end
    endgenerate
endmodule

// File: tb/tb_ram_dp_sr_sw_clr.sv
// tb/tb_ram_dp_sr_sw_clr.sv - directed bench for ram_dp_sr_sw_clr (two configurations)

module tb_ram_dp_sr_sw_clr;
    // dut_a: RD_MODE=0, OUT_REG=0 ; dut_b: RD_MODE=1, OUT_REG=1 ; same stimulus
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [4:0]  rd_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_dp_sr_sw_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .LANE_WIDTH(8)) if_a ();
    ram_dp_sr_sw_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .LANE_WIDTH(8)) if_b ();

    assign if_a.clr = clr;     assign if_b.clr = clr;
    assign if_a.wr_en = wr_en; assign if_b.wr_en = wr_en;
    assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
    assign if_a.wr_be = wr_be; assign if_b.wr_be = wr_be;
    assign if_a.rd_en = rd_en; assign if_b.rd_en = rd_en;
    assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr;

    ram_dp_sr_sw_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .LANE_WIDTH(8), .RD_MODE(0), .OUT_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    ram_dp_sr_sw_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .LANE_WIDTH(8), .RD_MODE(1), .OUT_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    // One read: A answers after the accepting edge, B one edge later.
    task automatic do_read(input logic [4:0] a, input logic [15:0] ea, input logic [15:0] eb, input string nm);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        checks++; if (if_a.rd_valid !== 1'b1) begin errors++; $display("FAIL %s a_valid: got %b expected 1", nm, if_a.rd_valid); end
        checks++; if (if_a.rd_data !== ea) begin errors++; $display("FAIL %s a_data: got %h expected %h", nm, if_a.rd_data, ea); end
        checks++; if (if_b.rd_valid !== 1'b0) begin errors++; $display("FAIL %s b_valid_early: got %b expected 0", nm, if_b.rd_valid); end
        step();
        checks++; if (if_a.rd_valid !== 1'b0) begin errors++; $display("FAIL %s a_valid_late: got %b expected 0", nm, if_a.rd_valid); end
        checks++; if (if_b.rd_valid !== 1'b1) begin errors++; $display("FAIL %s b_valid: got %b expected 1", nm, if_b.rd_valid); end
        checks++; if (if_b.rd_data !== eb) begin errors++; $display("FAIL %s b_data: got %h expected %h", nm, if_b.rd_data, eb); end
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 16'h0000, 16'h0000, nm);
        end
    endtask

    // Count edges until busy falls while wr_en/rd_en stay high; no read may return.
    task automatic sweep_count(input string nm);
        int cnt = 0;
        logic seen = 1'b0;
        wr_en = 1'b1; wr_data = 16'hFFFF; wr_be = 2'b11; rd_en = 1'b1;
        while (cnt < 100) begin
            step();
            cnt++;
            wr_addr = wr_addr + 5'd1;
            rd_addr = rd_addr + 5'd1;
            if (if_a.rd_valid || if_b.rd_valid) seen = 1'b1;
            if (!if_a.busy) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (cnt != 32) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 32", nm, cnt); end
        checks++; if (if_b.busy !== 1'b0) begin errors++; $display("FAIL %s b_busy_end: got %b expected 0", nm, if_b.busy); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL %s valid_during_busy: got %b expected 0", nm, seen); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        step(); step();
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL reset a_busy: got %b expected 1", if_a.busy); end
        checks++; if (if_a.rd_valid !== 1'b0) begin errors++; $display("FAIL reset a_valid: got %b expected 0", if_a.rd_valid); end
        checks++; if (if_a.rd_data !== 16'h0000) begin errors++; $display("FAIL reset a_data: got %h expected 0000", if_a.rd_data); end
        checks++; if (if_b.busy !== 1'b1) begin errors++; $display("FAIL reset b_busy: got %b expected 1", if_b.busy); end
        checks++; if (if_b.rd_data !== 16'h0000) begin errors++; $display("FAIL reset b_data: got %h expected 0000", if_b.rd_data); end
        rst_n = 1'b1;
        sweep_count("reset_sweep");
        read_all_zero("reset_zero");
    endtask

    task automatic test_write_read();
        do_write(5'd3, 16'hBEEF, 2'b11);
        do_read(5'd3, 16'hBEEF, 16'hBEEF, "wr_rd");
        step();
        checks++; if (if_a.rd_valid !== 1'b0 || if_a.rd_data !== 16'hBEEF) begin errors++; $display("FAIL hold_a: got %b/%h expected 0/beef", if_a.rd_valid, if_a.rd_data); end
        checks++; if (if_b.rd_valid !== 1'b0 || if_b.rd_data !== 16'hBEEF) begin errors++; $display("FAIL hold_b: got %b/%h expected 0/beef", if_b.rd_valid, if_b.rd_data); end
    endtask

    task automatic test_byte_enable();
        do_write(5'd3, 16'h1234, 2'b01);
        do_read(5'd3, 16'hBE34, 16'hBE34, "be_low");
        do_write(5'd3, 16'h56FF, 2'b10);
        do_read(5'd3, 16'h5634, 16'h5634, "be_high");
        do_write(5'd3, 16'h0000, 2'b00);
        do_read(5'd3, 16'h5634, 16'h5634, "be_none");
    endtask

    task automatic test_collision();
        do_write(5'd5, 16'hAAAA, 2'b11);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h5555; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 5'd5;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (if_a.rd_data !== 16'hAAAA) begin errors++; $display("FAIL coll_read_first: got %h expected aaaa", if_a.rd_data); end
        step();
        checks++; if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== 16'h5555) begin errors++; $display("FAIL coll_write_first: got %b/%h expected 1/5555", if_b.rd_valid, if_b.rd_data); end
        do_read(5'd5, 16'h5555, 16'h5555, "coll_after");
        do_write(5'd6, 16'hAAAA, 2'b11);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 16'h5555; wr_be = 2'b01;
        rd_en = 1'b1; rd_addr = 5'd6;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        checks++; if (if_b.rd_data !== 16'hAA55) begin errors++; $display("FAIL coll_partial: got %h expected aa55", if_b.rd_data); end
    endtask

    task automatic test_back_to_back();
        do_write(5'd1, 16'h1111, 2'b11);
        do_write(5'd2, 16'h2222, 2'b11);
        rd_en = 1'b1; rd_addr = 5'd1;
        step();
        checks++; if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== 16'h1111) begin errors++; $display("FAIL b2b_a1: got %b/%h expected 1/1111", if_a.rd_valid, if_a.rd_data); end
        rd_addr = 5'd2;
        step();
        rd_en = 1'b0;
        checks++; if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== 16'h2222) begin errors++; $display("FAIL b2b_a2: got %b/%h expected 1/2222", if_a.rd_valid, if_a.rd_data); end
        checks++; if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== 16'h1111) begin errors++; $display("FAIL b2b_b1: got %b/%h expected 1/1111", if_b.rd_valid, if_b.rd_data); end
        step();
        checks++; if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== 16'h2222) begin errors++; $display("FAIL b2b_b2: got %b/%h expected 1/2222", if_b.rd_valid, if_b.rd_data); end
        step();
        checks++; if (if_b.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_b_end: got %b expected 0", if_b.rd_valid); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 32; i++) begin
            do_write(5'(i), 16'h0101 * 16'(i + 1), 2'b11);
        end
        do_read(5'd31, 16'h2020, 16'h2020, "fill_check");
        // clr edge itself also carries a write and a read that must be dropped
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 5'd0;
        step();
        clr = 1'b0;
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b expected 1", if_a.busy); end
        checks++; if (if_a.rd_valid !== 1'b0) begin errors++; $display("FAIL clr_edge_read: got %b expected 0", if_a.rd_valid); end
        sweep_count("clr_sweep");
        read_all_zero("clr_zero");
    endtask

    task automatic test_reset_mid();
        do_write(5'd9, 16'h7777, 2'b11);
        do_write(5'd20, 16'h4242, 2'b11);
        do_read(5'd9, 16'h7777, 16'h7777, "pre_rst");
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        checks++; if (if_a.rd_data !== 16'h7777) begin errors++; $display("FAIL sweep_hold: got %h expected 7777", if_a.rd_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (if_a.busy !== 1'b1 || if_b.busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %b/%b expected 1/1", if_a.busy, if_b.busy); end
        checks++; if (if_a.rd_data !== 16'h0000 || if_b.rd_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_data: got %h/%h expected 0000/0000", if_a.rd_data, if_b.rd_data); end
        checks++; if (if_a.rd_valid !== 1'b0 || if_b.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b/%b expected 0/0", if_a.rd_valid, if_b.rd_valid); end
        step(); step();
        rst_n = 1'b1;
        sweep_count("rst_sweep");
        read_all_zero("rst_zero");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
